key_debounce: RTL and testbench

//   Conditions the raw active-low push-button inputs (KEY[3:0]) into clean per-key

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 127 ++++++++++++
 rtl/key_debounce.sv | 47 ++++
 tb/tb_key_debounce.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debounce channels: FSM state encoding
// and a counter-width helper used to validate CNT_W at elaboration.
package key_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_DB   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_RELEASE_DB = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    PRESS_DB   = ST_PRESS_DB,
    HELD       = ST_HELD,
    RELEASE_DB = ST_RELEASE_DB
  } key_state_e;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned cnt_bits(input int unsigned v);
    int unsigned n;
    n = 1;
    while ((v >> n) != 0) n++;
    return n;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce FSM, auto-repeat timer.
// All outputs are registered.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100,
  parameter int unsigned CNT_W          = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam bit               REP_EN     = (REPEAT_DELAY != 0);

  logic             sync1, sync2, ks;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_rate_q, rep_rate_d;
  logic             rep_hit;
  logic             level_d, press_d, release_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign ks = ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_rate_q  <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_rate_q  <= rep_rate_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      key_repeat  <= rep_hit;
    end
  end

  // Repeat counter restarts at 0 on each pulse (first interval DELAY, then RATE),
  // which is equivalent to counting to DELAY, DELAY+RATE, ... without ever wrapping.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    rep_rate_d = rep_rate_q;
    rep_hit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ks) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!ks) begin
          state_d = IDLE;
        end else if (tick) begin
          if (db_cnt_q == DB_LAST) begin
            state_d    = HELD;
            rep_cnt_d  = '0;
            rep_rate_d = 1'b0;
          end else begin
            db_cnt_d = sat_inc(db_cnt_q);
          end
        end
      end
      HELD: begin
        if (tick && REP_EN) begin
          if (rep_cnt_q == (rep_rate_q ? RATE_LAST : DELAY_LAST)) begin
            rep_hit    = 1'b1;
            rep_cnt_d  = '0;
            rep_rate_d = 1'b1;
          end else begin
            rep_cnt_d = sat_inc(rep_cnt_q);
          end
        end
        if (!ks) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (ks) begin
          state_d = HELD;
        end else if (tick) begin
          if (db_cnt_q == DB_LAST) state_d = IDLE;
          else                     db_cnt_d = sat_inc(db_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d   = (state_d == HELD) || (state_d == RELEASE_DB);
    press_d   = (state_q == PRESS_DB)   && (state_d == HELD);
    release_d = (state_q == RELEASE_DB) && (state_d == IDLE);
  end

endmodule

// File: rtl/key_debounce.sv
// Debounced, auto-repeating key conditioner: fans NKEYS raw active-low keys
// out to independent key_debounce_ch channels.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NKEYS          = 4,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned REPEAT_DELAY   = 500,
  parameter int unsigned REPEAT_RATE    = 100,
  parameter int unsigned CNT_W          = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat
);

  localparam int unsigned MAX_A   = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;

  if (cnt_bits(MAX_CNT) > CNT_W) begin : g_cnt_w_check
    $error("key_debounce: CNT_W too small for configured tick counts");
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE),
      .CNT_W         (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: an event-level reference model queues
// expected pulses; a negedge monitor pops and compares them.
module tb_key_debounce;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick  = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  always #5 clk = ~clk;

  key_debounce #(
    .NKEYS(NK), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  typedef struct packed {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] rep;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, failures = 0, cyc = 0;

  // Reference model: per key, the synchronised view of the key is the raw input
  // two edges ago; a change is accepted after DB ticks of continuous
  // disagreement (the first disagreeing edge never counts); repeats fire when
  // held-tick count hits RD, RD+RR, RD+2RR, ...
  logic [NK-1:0] h1 = '1, h2 = '1;
  logic [NK-1:0] m_level = '0;
  int m_age[NK], m_cnt[NK], m_held[NK];

  int cnt_press[NK], cnt_rel[NK], cnt_rep[NK], last_press[NK], last_rel[NK];
  logic [NK-1:0] lvl_seen = '0;

  initial begin
    ev_t  e;
    logic ks;
    for (int k = 0; k < NK; k++) begin m_age[k] = 0; m_cnt[k] = 0; m_held[k] = 0; end
    forever begin
      @(posedge clk);
      cyc++;
      e = '{cyc: cyc, press: '0, rel: '0, rep: '0};
      if (!rst_n) begin
        h1 = '1; h2 = '1; m_level = '0;
        for (int k = 0; k < NK; k++) begin m_age[k] = 0; m_cnt[k] = 0; m_held[k] = 0; end
      end else begin
        for (int k = 0; k < NK; k++) begin
          ks = ~h2[k];
          if (m_level[k] && m_age[k] == 0 && tick && RD != 0) begin
            m_held[k]++;
            if (m_held[k] >= RD && (m_held[k] - RD) % RR == 0) e.rep[k] = 1'b1;
          end
          if (ks == m_level[k]) begin
            m_age[k] = 0; m_cnt[k] = 0;
          end else begin
            if (m_age[k] > 0 && tick) m_cnt[k]++;
            m_age[k]++;
            if (m_cnt[k] == DB) begin
              m_level[k] = ks; m_age[k] = 0; m_cnt[k] = 0;
              if (ks) begin e.press[k] = 1'b1; m_held[k] = 0; end
              else e.rel[k] = 1'b1;
            end
          end
        end
        h2 = h1; h1 = key_n;
      end
      if ((e.press | e.rel | e.rep) != '0) exp_q.push_back(e);
    end
  end

  initial begin
    ev_t e;
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] = 0; cnt_rel[k] = 0; cnt_rep[k] = 0; last_press[k] = -1; last_rel[k] = -1;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if ((key_level | key_press | key_release | key_repeat) != '0) begin
          failures++;
          $display("FAIL reset_outputs cyc=%0d lvl=%b p=%b r=%b rp=%b expected all 0",
                   cyc, key_level, key_press, key_release, key_repeat);
        end
      end else begin
        checks++;
        if (key_level !== m_level) begin
          failures++;
          $display("FAIL level cyc=%0d got=%b exp=%b", cyc, key_level, m_level);
        end
        lvl_seen |= key_level;
        for (int k = 0; k < NK; k++) begin
          if (key_press[k])   begin cnt_press[k]++; last_press[k] = cyc; end
          if (key_release[k]) begin cnt_rel[k]++;   last_rel[k]   = cyc; end
          if (key_repeat[k])  cnt_rep[k]++;
        end
        if ((key_press | key_release | key_repeat) != '0 ||
            (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d p=%b r=%b rp=%b expected none",
                     cyc, key_press, key_release, key_repeat);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.press !== key_press || e.rel !== key_release || e.rep !== key_repeat) begin
              failures++;
              $display("FAIL pulse cyc=%0d got p=%b r=%b rp=%b exp cyc=%0d p=%b r=%b rp=%b",
                       cyc, key_press, key_release, key_repeat, e.cyc, e.press, e.rel, e.rep);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int k = 0; k < NK; k++) begin
      cnt_press[k] = 0; cnt_rel[k] = 0; cnt_rep[k] = 0; last_press[k] = -1; last_rel[k] = -1;
    end
    lvl_seen = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d expected end before timeout", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, p;
    int rem[NK];

    step(3);
    chk("reset_level", int'(key_level), 0);
    chk("reset_pulses", int'(key_press | key_release | key_repeat), 0);
    rst_n = 1'b1;
    step(3);

    // 1: clean press, 7 clk latency
    clr();
    key_n[0] = 1'b0; t = cyc;
    step(10); settle();
    chk("t1_press_cyc", last_press[0], t + 7);
    chk("t1_press_cnt", cnt_press[0], 1);
    chk("t1_other_press", cnt_press[1] + cnt_press[2] + cnt_press[3], 0);
    chk("t1_level", int'(key_level[0]), 1);
    key_n[0] = 1'b1;
    step(10);

    // 2: bounce on key 1
    clr();
    for (int i = 0; i < 10; i++) begin key_n[1] = ~key_n[1]; step(2); end
    step(8); settle();
    chk("t2_press", cnt_press[1], 0);
    chk("t2_release", cnt_rel[1], 0);
    chk("t2_level_seen", int'(lvl_seen[1]), 0);

    // 3: auto-repeat on key 2
    clr();
    key_n[2] = 1'b0;
    for (int i = 0; i < 20 && cnt_press[2] == 0; i++) step(1);
    chk("t3_press_seen", cnt_press[2], 1);
    p = last_press[2];
    while (cyc < p + 40) step(1);
    settle();
    chk("t3_repeats", cnt_rep[2], 11);
    chk("t3_press_cnt", cnt_press[2], 1);
    key_n[2] = 1'b1;
    step(12);

    // 4: release glitch then clean release
    clr();
    key_n[0] = 1'b0;
    step(10);
    key_n[0] = 1'b1; step(2);
    key_n[0] = 1'b0; step(10); settle();
    chk("t4_glitch_release", cnt_rel[0], 0);
    chk("t4_glitch_level", int'(key_level[0]), 1);
    key_n[0] = 1'b1; t = cyc;
    step(10); settle();
    chk("t4_release_cyc", last_rel[0], t + 7);
    chk("t4_release_cnt", cnt_rel[0], 1);
    chk("t4_level", int'(key_level[0]), 0);

    // 5: tick gating
    clr();
    tick = 1'b0;
    key_n[1] = 1'b0;
    step(50); settle();
    chk("t5_gated_press", cnt_press[1], 0);
    chk("t5_gated_level", int'(key_level[1]), 0);
    step(1);
    tick = 1'b1; t = cyc;
    step(8); settle();
    chk("t5_press_cyc", last_press[1], t + 4);
    key_n[1] = 1'b1;
    step(10);

    // 6: reset while held
    clr();
    key_n[3] = 1'b0;
    step(10); settle();
    chk("t6_held_level", int'(key_level[3]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_level", int'(key_level), 0);
    chk("t6_async_pulses", int'(key_press | key_release | key_repeat), 0);
    step(3);
    clr();
    rst_n = 1'b1; t = cyc;
    step(10); settle();
    chk("t6_press_cyc", last_press[3], t + 7);
    chk("t6_no_release", cnt_rel[3], 0);
    key_n[3] = 1'b1;
    step(12);

    // Randomised holds and bounces with a random tick strobe
    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 40);
    for (int i = 0; i < 4000; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key_n[k] = ~key_n[k];
          rem[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 60);
        end else begin
          rem[k]--;
        end
      end
      step(1);
    end
    tick = 1'b1;
    key_n = '1;
    step(30); settle();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_level", int'(key_level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
